// File: rtl/irq_pkg.sv
// Shared constants, state encoding and small helpers for the seven-line
// interrupt controller (irq_ctrl7).
//   N_IRQ     number of request lines (numbered 1..7)
//   VEC_W     width of a vector number
//   VEC_NONE  vector value meaning "no line"
//   MASK_RST  mask value after reset (every line masked)
package irq_pkg;

  localparam int         N_IRQ    = 7;
  localparam int         VEC_W    = 3;
  localparam logic [2:0] VEC_NONE = 3'd0;
  localparam logic [7:1] MASK_RST = 7'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    SERV = 2'd2
  } irq_state_e;

  // Number of the lowest set bit (1..7), or 0 when the vector is empty.
  function automatic logic [2:0] lowest_set(input logic [7:1] v);
    logic [2:0] res;
    res = VEC_NONE;
    for (int i = 7; i >= 1; i--) begin
      if (v[i]) res = 3'(i);
    end
    return res;
  endfunction

  // One-hot line mask for a vector number; 0 selects nothing.
  function automatic logic [7:1] onehot(input logic [2:0] v);
    logic [7:1] res;
    res = '0;
    for (int i = 1; i <= 7; i++) begin
      if (v == 3'(i)) res[i] = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Per-line input synchroniser, edge detector and trigger-mode select.
//   c      clock
//   r      synchronous active-high reset
//   a      [7:1] raw asynchronous request lines
//   set_v  [7:1] registered "set pending" vector for the controller
// Parameters: SYNC_STAGES (2 or 3 flops per line), EDGE (1 rising edge,
// 0 level).
module irq_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE        = 1
) (
  input  logic       c,
  input  logic       r,
  input  logic [7:1] a,
  output logic [7:1] set_v
);

  logic [7:1] sync_q [SYNC_STAGES];
  logic [7:1] prev_q;
  logic [7:1] s;

  assign s = sync_q[SYNC_STAGES-1];

  // set_v is registered, giving one extra cycle after the synchroniser
  // before a request lands in the pending register.
  always_ff @(posedge c) begin
    if (r) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
      set_v  <= '0;
    end else begin
      sync_q[0] <= a;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= s;
      set_v  <= (EDGE != 0) ? (s & ~prev_q) : s;
    end
  end

endmodule

// File: rtl/priority7.sv
// Seven-input priority encoder. Line 1 has the highest priority.
//   req  [7:1]  request vector
//   idx  [2:0]  number of the lowest set request line, 0 when none
module priority7 (
  input  logic [7:1] req,
  output logic [2:0] idx
);

  always_comb begin
    idx = 3'd0;
    // Walk from the lowest priority up so the lowest set line wins.
    for (int i = 7; i >= 1; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule

// File: rtl/irq_ctrl7.sv
// Seven-line interrupt controller. Synchronises raw requests, latches them
// as pending, masks them and presents the highest-priority vector to the CPU.
//   c        clock (rising edge)
//   r        synchronous active-high reset
//   a        [7:1] raw request lines
//   mask_we  write strobe for mask_d
//   mask_d   [7:1] new mask (1 = masked)
//   mask_q   [7:1] current mask
//   pend_q   [7:1] current pending register
//   irq      interrupt request to the CPU
//   vec      [2:0] line requested / in service, 0 = none
//   ack      CPU accepts vec (one-cycle pulse)
//   eoi      end of interrupt (one-cycle pulse)
//   busy     an interrupt is in service
//   state    FSM state, for observation
// Optional: define IRQ_NEST_EN to allow higher-priority lines to nest on top
// of an interrupt already in service (in-service register isr).
//
// Handshake: irq is high only in PEND (or, when nesting, while a pre-empting
// line is offered in SERV). An ack counts only in a cycle where irq is high;
// it freezes vec and clears that line's pending bit. An eoi counts only in
// SERV. Any ack/eoi outside those windows is ignored.
module irq_ctrl7
  import irq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE        = 1
) (
  input  logic       c,
  input  logic       r,
  input  logic [7:1] a,
  input  logic       mask_we,
  input  logic [7:1] mask_d,
  output logic [7:1] mask_q,
  output logic [7:1] pend_q,
  output logic       irq,
  output logic [2:0] vec,
  input  logic       ack,
  input  logic       eoi,
  output logic       busy,
  output irq_state_e state
);

  logic [7:1] set_v;
  logic [7:1] active;
  logic [7:1] clr;
  logic [7:1] pend_n;
  logic [2:0] enc;
  irq_state_e state_n;
  logic       irq_n;
  logic       busy_n;
  logic [2:0] vec_n;
`ifdef IRQ_NEST_EN
  logic [7:1] isr_q;
  logic [7:1] isr_n;
  logic [2:0] top;
`endif

  irq_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .EDGE       (EDGE)
  ) u_sync (
    .c    (c),
    .r    (r),
    .a    (a),
    .set_v(set_v)
  );

  // Mask gates requests only; pending bits latch regardless.
  assign active = pend_q & ~mask_q;

  priority7 u_prio (
    .req(active),
    .idx(enc)
  );

  // A new set beats a same-cycle clear of the same bit.
  assign pend_n = (pend_q & ~clr) | set_v;

  always_comb begin
    state_n = state;
    irq_n   = irq;
    busy_n  = busy;
    vec_n   = vec;
    clr     = '0;
`ifdef IRQ_NEST_EN
    isr_n   = isr_q;
    top     = VEC_NONE;
`endif
    case (state)
      IDLE: begin
        irq_n  = 1'b0;
        busy_n = 1'b0;
        vec_n  = VEC_NONE;
        if (active != '0) begin
          state_n = PEND;
          irq_n   = 1'b1;
          vec_n   = enc;
        end
      end
      PEND: begin
        if (active == '0) begin
          // Request withdrawn (masked) before the CPU took it.
          state_n = IDLE;
          irq_n   = 1'b0;
          vec_n   = VEC_NONE;
        end else if (ack) begin
          clr     = onehot(vec);
          state_n = SERV;
          irq_n   = 1'b0;
          busy_n  = 1'b1;
`ifdef IRQ_NEST_EN
          isr_n   = onehot(vec);
`endif
        end else begin
          irq_n = 1'b1;
          vec_n = enc;
        end
      end
      SERV: begin
`ifdef IRQ_NEST_EN
        if (ack && irq) begin
          clr   = onehot(vec);
          isr_n = isr_n | onehot(vec);
        end
        if (eoi) begin
          isr_n = isr_n & ~onehot(lowest_set(isr_q));
        end
        top = lowest_set(isr_n);
        if (isr_n == '0) begin
          state_n = IDLE;
          irq_n   = 1'b0;
          busy_n  = 1'b0;
          vec_n   = VEC_NONE;
        end else begin
          busy_n = 1'b1;
          // Offer a line only if it outranks everything already in service.
          if (enc != VEC_NONE && enc < top) begin
            irq_n = 1'b1;
            vec_n = enc;
          end else begin
            irq_n = 1'b0;
            vec_n = top;
          end
        end
`else
        irq_n  = 1'b0;
        busy_n = 1'b1;
        if (eoi) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          vec_n   = VEC_NONE;
        end
`endif
      end
      default: begin
        state_n = IDLE;
        irq_n   = 1'b0;
        busy_n  = 1'b0;
        vec_n   = VEC_NONE;
      end
    endcase
  end

  always_ff @(posedge c) begin
    if (r) begin
      state  <= IDLE;
      irq    <= 1'b0;
      busy   <= 1'b0;
      vec    <= VEC_NONE;
      mask_q <= MASK_RST;
      pend_q <= '0;
`ifdef IRQ_NEST_EN
      isr_q  <= '0;
`endif
    end else begin
      state  <= state_n;
      irq    <= irq_n;
      busy   <= busy_n;
      vec    <= vec_n;
      pend_q <= pend_n;
      if (mask_we) mask_q <= mask_d;
`ifdef IRQ_NEST_EN
      isr_q  <= isr_n;
`endif
    end
  end

endmodule

// File: tb/tb_irq_ctrl7.sv
module tb_irq_ctrl7;
  import irq_pkg::*;

  logic       c = 1'b0;
  logic       r = 1'b1;
  logic [7:1] a = '0;
  logic       mask_we = 1'b0;
  logic [7:1] mask_d = '0;
  logic       ack = 1'b0;
  logic       eoi = 1'b0;

  logic [7:1] mask_e, pend_e, mask_l, pend_l;
  logic       irq_e, busy_e, irq_l, busy_l;
  logic [2:0] vec_e, vec_l;
  irq_state_e state_e, state_l;

  int checks = 0;
  int failures = 0;

  // Edge-triggered instance (default parameters).
  irq_ctrl7 #(.SYNC_STAGES(2), .EDGE(1)) dut (
    .c(c), .r(r), .a(a), .mask_we(mask_we), .mask_d(mask_d),
    .mask_q(mask_e), .pend_q(pend_e), .irq(irq_e), .vec(vec_e),
    .ack(ack), .eoi(eoi), .busy(busy_e), .state(state_e)
  );

  // Level-triggered instance sharing the same stimulus.
  irq_ctrl7 #(.SYNC_STAGES(2), .EDGE(0)) dut_lvl (
    .c(c), .r(r), .a(a), .mask_we(mask_we), .mask_d(mask_d),
    .mask_q(mask_l), .pend_q(pend_l), .irq(irq_l), .vec(vec_l),
    .ack(ack), .eoi(eoi), .busy(busy_l), .state(state_l)
  );

  // Clock
  always #5 c = ~c;

  // Driver tasks: inputs change and outputs are sampled just after negedge.
  task automatic step(input int n);
    repeat (n) @(negedge c);
  endtask

  task automatic do_reset();
    r = 1'b1; a = '0; ack = 1'b0; eoi = 1'b0; mask_we = 1'b0;
    step(2);
    r = 1'b0;
  endtask

  task automatic write_mask(input logic [7:1] m);
    mask_we = 1'b1; mask_d = m;
    step(1);
    mask_we = 1'b0;
  endtask

  task automatic pulse_a(input logic [7:1] m);
    a = a | m;
    step(1);
    a = a & ~m;
  endtask

  task automatic pulse_ack();
    ack = 1'b1; step(1); ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; step(1); eoi = 1'b0;
  endtask

  task automatic wait_irq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (irq_e) begin ok = 1'b1; break; end
      step(1);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mask_e !== 7'h7F) begin failures++; $display("FAIL rst_mask got=%h exp=7f", mask_e); end
    checks++; if (pend_e !== 7'h00) begin failures++; $display("FAIL rst_pend got=%h exp=00", pend_e); end
    checks++; if ({irq_e, busy_e, vec_e} !== 5'b0) begin failures++; $display("FAIL rst_outs got=%b exp=00000", {irq_e, busy_e, vec_e}); end
    checks++; if (state_e !== IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=0", state_e); end
  endtask

  task automatic test_basic();
    write_mask(7'h00);
    pulse_a(7'b0010000);
    step(2);
    checks++; if (pend_e !== 7'h00) begin failures++; $display("FAIL t1_pend_early got=%h exp=00", pend_e); end
    step(1);
    checks++; if (pend_e !== 7'b0010000) begin failures++; $display("FAIL t1_pend got=%h exp=10", pend_e); end
    checks++; if (irq_e !== 1'b0) begin failures++; $display("FAIL t1_irq_early got=%b exp=0", irq_e); end
    step(1);
    checks++; if (irq_e !== 1'b1 || vec_e !== 3'd5) begin failures++; $display("FAIL t1_irq got=%b/%0d exp=1/5", irq_e, vec_e); end
    pulse_ack();
    checks++; if (pend_e !== 7'h00 || busy_e !== 1'b1 || irq_e !== 1'b0 || vec_e !== 3'd5) begin
      failures++; $display("FAIL t1_ack pend=%h busy=%b irq=%b vec=%0d exp=00/1/0/5", pend_e, busy_e, irq_e, vec_e); end
    pulse_eoi();
    checks++; if (busy_e !== 1'b0 || vec_e !== 3'd0 || state_e !== IDLE) begin
      failures++; $display("FAIL t1_eoi busy=%b vec=%0d state=%0d exp=0/0/0", busy_e, vec_e, state_e); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    do_reset(); write_mask(7'h00);
    pulse_a(7'b0100010);
    wait_irq(ok);
    checks++; if (!ok) begin failures++; $display("FAIL t2_timeout got=0 exp=1"); end
    checks++; if (vec_e !== 3'd2 || pend_e !== 7'b0100010) begin failures++; $display("FAIL t2_vec vec=%0d pend=%h exp=2/22", vec_e, pend_e); end
    pulse_ack();
    checks++; if (pend_e !== 7'b0100000 || vec_e !== 3'd2) begin failures++; $display("FAIL t2_ack pend=%h vec=%0d exp=20/2", pend_e, vec_e); end
    pulse_eoi();
    checks++; if (irq_e !== 1'b0 || vec_e !== 3'd0) begin failures++; $display("FAIL t2_eoi irq=%b vec=%0d exp=0/0", irq_e, vec_e); end
    step(1);
    checks++; if (irq_e !== 1'b1 || vec_e !== 3'd6) begin failures++; $display("FAIL t2_next irq=%b vec=%0d exp=1/6", irq_e, vec_e); end
    pulse_ack(); pulse_eoi();
  endtask

  task automatic test_preempt();
    bit ok;
    bit found;
    do_reset(); write_mask(7'h00);
    pulse_a(7'b0001000);
    wait_irq(ok);
    checks++; if (!ok || vec_e !== 3'd4) begin failures++; $display("FAIL t3_first ok=%b vec=%0d exp=1/4", ok, vec_e); end
    pulse_a(7'b0000001);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (vec_e == 3'd1) begin found = 1'b1; break; end
      step(1);
    end
    checks++; if (!found || irq_e !== 1'b1 || state_e !== PEND || pend_e !== 7'b0001001) begin
      failures++; $display("FAIL t3_preempt found=%b irq=%b state=%0d pend=%h exp=1/1/1/09", found, irq_e, state_e, pend_e); end
    pulse_ack();
    checks++; if (pend_e !== 7'b0001000 || vec_e !== 3'd1 || busy_e !== 1'b1) begin
      failures++; $display("FAIL t3_ack pend=%h vec=%0d busy=%b exp=08/1/1", pend_e, vec_e, busy_e); end
    pulse_eoi(); step(1);
    checks++; if (irq_e !== 1'b1 || vec_e !== 3'd4) begin failures++; $display("FAIL t3_resume irq=%b vec=%0d exp=1/4", irq_e, vec_e); end
    // ack and eoi together in PEND: only ack acts
    ack = 1'b1; eoi = 1'b1; step(1); ack = 1'b0; eoi = 1'b0;
    checks++; if (state_e !== SERV || busy_e !== 1'b1 || vec_e !== 3'd4) begin
      failures++; $display("FAIL t3_ack_eoi state=%0d busy=%b vec=%0d exp=2/1/4", state_e, busy_e, vec_e); end
    pulse_eoi();
  endtask

  task automatic test_mask();
    do_reset();
    pulse_a(7'b0000100);
    step(6);
    checks++; if (pend_e !== 7'b0000100 || irq_e !== 1'b0) begin failures++; $display("FAIL t4_masked pend=%h irq=%b exp=04/0", pend_e, irq_e); end
    write_mask(7'h00);
    checks++; if (mask_e !== 7'h00 || irq_e !== 1'b0) begin failures++; $display("FAIL t4_wr mask=%h irq=%b exp=00/0", mask_e, irq_e); end
    step(1);
    checks++; if (irq_e !== 1'b1 || vec_e !== 3'd3) begin failures++; $display("FAIL t4_unmask irq=%b vec=%0d exp=1/3", irq_e, vec_e); end
    write_mask(7'h7F);
    step(1);
    checks++; if (irq_e !== 1'b0 || vec_e !== 3'd0 || state_e !== IDLE || pend_e !== 7'b0000100) begin
      failures++; $display("FAIL t4_remask irq=%b vec=%0d state=%0d pend=%h exp=0/0/0/04", irq_e, vec_e, state_e, pend_e); end
  endtask

  task automatic test_level();
    bit ok;
    do_reset(); write_mask(7'h00);
    a = 7'b1000000;
    wait_irq(ok);
    checks++; if (!ok || vec_e !== 3'd7 || irq_l !== 1'b1 || vec_l !== 3'd7) begin
      failures++; $display("FAIL t5_first ok=%b vec_e=%0d irq_l=%b vec_l=%0d exp=1/7/1/7", ok, vec_e, irq_l, vec_l); end
    pulse_ack();
    checks++; if (pend_l !== 7'b1000000 || pend_e !== 7'h00) begin failures++; $display("FAIL t5_ack pend_l=%h pend_e=%h exp=40/00", pend_l, pend_e); end
    pulse_eoi(); step(1);
    checks++; if (irq_l !== 1'b1 || vec_l !== 3'd7) begin failures++; $display("FAIL t5_lvl_again irq=%b vec=%0d exp=1/7", irq_l, vec_l); end
    step(3);
    checks++; if (irq_e !== 1'b0 || pend_e !== 7'h00) begin failures++; $display("FAIL t5_edge_quiet irq=%b pend=%h exp=0/00", irq_e, pend_e); end
    a = '0;
  endtask

  task automatic test_reset_mid_service();
    bit ok;
    do_reset(); write_mask(7'h00);
    pulse_a(7'b0000010);
    wait_irq(ok);
    pulse_ack();
    checks++; if (!ok || busy_e !== 1'b1) begin failures++; $display("FAIL t6_serv ok=%b busy=%b exp=1/1", ok, busy_e); end
    r = 1'b1; ack = 1'b1; eoi = 1'b1; mask_we = 1'b1; mask_d = 7'h00;
    step(1);
    r = 1'b0; ack = 1'b0; eoi = 1'b0; mask_we = 1'b0;
    checks++; if ({irq_e, busy_e, vec_e} !== 5'b0 || mask_e !== 7'h7F || pend_e !== 7'h00 || state_e !== IDLE) begin
      failures++; $display("FAIL t6_rst outs=%b mask=%h pend=%h state=%0d exp=00000/7f/00/0", {irq_e, busy_e, vec_e}, mask_e, pend_e, state_e); end
    pulse_a(7'b0100000);
    step(5);
    pulse_ack();
    checks++; if (pend_e !== 7'b0100000 || state_e !== IDLE || busy_e !== 1'b0) begin
      failures++; $display("FAIL t6_idle_ack pend=%h state=%0d busy=%b exp=20/0/0", pend_e, state_e, busy_e); end
    pulse_eoi();
    checks++; if (state_e !== IDLE || busy_e !== 1'b0 || vec_e !== 3'd0) begin
      failures++; $display("FAIL t6_idle_eoi state=%0d busy=%b vec=%0d exp=0/0/0", state_e, busy_e, vec_e); end
  endtask

`ifdef IRQ_NEST_EN
  task automatic test_nest();
    bit ok;
    do_reset(); write_mask(7'h00);
    pulse_a(7'b0010000);
    wait_irq(ok);
    pulse_ack();
    checks++; if (!ok || busy_e !== 1'b1 || vec_e !== 3'd5) begin failures++; $display("FAIL t7_serv5 ok=%b busy=%b vec=%0d exp=1/1/5", ok, busy_e, vec_e); end
    pulse_a(7'b0000010);
    wait_irq(ok);
    checks++; if (!ok || vec_e !== 3'd2 || busy_e !== 1'b1) begin failures++; $display("FAIL t7_nest ok=%b vec=%0d busy=%b exp=1/2/1", ok, vec_e, busy_e); end
    pulse_ack();
    checks++; if (irq_e !== 1'b0 || vec_e !== 3'd2 || pend_e !== 7'h00) begin failures++; $display("FAIL t7_ack irq=%b vec=%0d pend=%h exp=0/2/00", irq_e, vec_e, pend_e); end
    pulse_eoi();
    checks++; if (vec_e !== 3'd5 || busy_e !== 1'b1) begin failures++; $display("FAIL t7_eoi1 vec=%0d busy=%b exp=5/1", vec_e, busy_e); end
    pulse_eoi();
    checks++; if (busy_e !== 1'b0 || vec_e !== 3'd0 || state_e !== IDLE) begin failures++; $display("FAIL t7_eoi2 busy=%b vec=%0d state=%0d exp=0/0/0", busy_e, vec_e, state_e); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_simultaneous();
    test_preempt();
    test_mask();
    test_level();
    test_reset_mid_service();
`ifdef IRQ_NEST_EN
    test_nest();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/irq_ctrl7.md
Name: irq_ctrl7

Overview:
- Seven-line interrupt controller.
- Synchronises raw request lines, latches them as pending, applies a mask, and presents the highest-priority vector to the CPU side with an irq/ack/eoi handshake.
- Sits directly upstream of the library priority encoder, which it instantiates for vector selection.
- Lowest-numbered line has the highest priority, matching priority7.

Parameters:
- SYNC_STAGES, 2: flops per request line in the input synchroniser. Legal values are 2 or 3.
- EDGE, 1: trigger mode. 1 = rising-edge triggered; 0 = level triggered.

Ports:
- c  input  1  clock; everything is on the rising edge.
- r  input  1  reset; synchronous, active-high.
- a  input  [7:1]  raw asynchronous request lines.
- mask_we  input  1  when high, mask_d is written into the mask register.
- mask_d  input  [7:1]  new mask value; 1 = line masked.
- mask_q  output  [7:1]  current mask register.
- pend_q  output  [7:1]  current pending register.
- irq  output  1  interrupt request to the CPU.
- vec  output  [2:0]  line number being requested or serviced; 0 = none.
- ack  input  1  CPU accepts the current vec; single-cycle pulse.
- eoi  input  1  end of interrupt; single-cycle pulse.
- busy  output  1  an interrupt is in service.

Behaviour:
- Reset (r=1 at a clock edge):
  - synchroniser, edge-history and pend all 0
  - mask = 7'h7F (all lines masked)
  - state = IDLE
  - irq, busy and vec = 0
  - r overrides all other inputs in that cycle, including a reset that arrives mid-service.
- Synchroniser: each a[i] passes through SYNC_STAGES flops; s[i] is the last stage.
- Pending set:
  - EDGE=1: pend[i] sets when s[i]=1 and the previous s[i]=0.
  - EDGE=0: pend[i] sets whenever s[i]=1.
  - pend bits are set regardless of mask. Masking gates only requests, not latching.
- Pending clear: pend[vec] clears on an accepted ack. If a set and a clear for the same bit occur in the same cycle, the set wins.
- active = pend & ~mask. enc = priority encode of active (0 if none).
- Latency (EDGE=1): a rise sampled at edge k makes pend visible after edge k+SYNC_STAGES+1, and irq after edge k+SYNC_STAGES+2.
- State machine (registered; irq/busy/vec are registered outputs):
  - IDLE: irq=0, busy=0, vec=0. If active≠0, go to PEND and load vec=enc.
  - PEND: irq=1, and vec reloads enc every cycle, so a higher-priority arrival pre-empts before ack.
    - If active becomes 0 (for example, the line is masked), go to IDLE with irq=0 and vec=0.
    - On ack: freeze vec, clear pend[vec], go to SERV.
  - SERV: irq=0, busy=1, vec holds the serviced line. On eoi, go to IDLE, busy=0, vec=0.
    - The next request can raise irq one cycle after that.
- Ignored inputs: ack outside PEND, and eoi outside SERV. If ack and eoi arrive together, only the one legal in the current state acts.
- Mask writes: mask_we updates mask_q at the next edge. New mask values affect active from that edge on, and may withdraw irq while in PEND.

Optional Feature:
- Macro IRQ_NEST_EN.
- Defined:
  - A 7-bit in-service register isr replaces the single SERV state.
  - In SERV, if enc is non-zero and its line is higher priority (lower number) than the lowest set isr bit, irq=1 and vec=enc.
  - ack sets isr[enc] and clears pend[enc].
  - eoi clears the lowest set isr bit, and vec returns to the next lowest set isr bit.
  - The block returns to IDLE when isr becomes empty. busy = |isr.
- Undefined: no nesting, exactly as described under Behaviour. isr logic is absent.

Decomposition:
- Package irq_pkg:
  - constants N_IRQ=7, VEC_W=3, VEC_NONE=3'd0, MASK_RST=7'h7F
  - state encoding IDLE/PEND/SERV (2-bit enum).
- Sub-module irq_sync holds the per-line synchroniser, edge detector and EDGE-mode select, and outputs the 7-bit set vector.
- Vector selection instantiates priority7.

Test Plan:
1. Reset, write mask=0, pulse a[5] high for 1 cycle → pend_q[5]=1 after 3 edges and irq=1/vec=5 after 4 edges. Then ack → pend_q[5]=0, busy=1. Then eoi → busy=0, vec=0.
2. a[6] and a[2] rise on the same cycle → vec=2. Ack, eoi, then irq again with vec=6.
3. In PEND with vec=4, a[1] rises → vec changes to 1 before ack. Ack clears only pend[1].
4. Mask=7'h7F, raise a[3] → pend_q[3]=1 and irq stays 0. Write mask=0 → irq=1, vec=3. Re-mask while in PEND → irq=0, state IDLE.
5. EDGE=0, hold a[7] high → after ack and eoi, irq reasserts with vec=7. With EDGE=1 and a[7] still held high → no reassertion.
6. Assert r while in SERV → all outputs return to reset values on the next edge, mask_q=7'h7F. Ack or eoi issued in IDLE has no effect.
7. IRQ_NEST_EN defined: in service of line 5, raise a[2] → irq=1, vec=2. Ack → isr=0b0010010. Eoi → vec=5, busy=1. Second eoi → busy=0.
